// File: rtl/spinner_multi.sv
// Multi-channel rotary position generator: digital step requests paced by the
// frame strobe plus analog spinner deltas, combined into a wrapping or saturating position.
module spinner_multi #(
  parameter int          CHANNELS   = 2,
  parameter int          OUT_W      = 4,
  parameter int          SLOW_RATE  = 8,
  parameter int          FAST_RATE  = 2,
  parameter int          SPIN_SHIFT = 2,
  parameter int unsigned CLAMP_MASK = 0,
  parameter int          INIT       = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      strobe,
  input  logic [CHANNELS-1:0]       fast,
  input  logic [CHANNELS-1:0]       minus,
  input  logic [CHANNELS-1:0]       plus,
  input  logic [9*CHANNELS-1:0]     spin_in,
  output logic [OUT_W*CHANNELS-1:0] spin_out,
  output logic [CHANNELS-1:0]       moved
);

  localparam int TW = 9 + SPIN_SHIFT;
  localparam int FW = (SPIN_SHIFT > 0) ? SPIN_SHIFT : 1;
  localparam logic signed [11:0] MAX_POS = 12'((1 << OUT_W) - 1);

  logic str_d;
  logic armed;
  logic sample;

  // armed stays low for the first cycle after reset so a toggle bit that was
  // already set does not look like a fresh analog sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      str_d <= 1'b0;
      armed <= 1'b0;
    end else begin
      str_d <= strobe;
      armed <= 1'b1;
    end
  end

  assign sample = strobe & ~str_d;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    localparam bit CLAMP = ((CLAMP_MASK >> c) & 1) != 0;

    logic [7:0]             cnt, cnt_next, rate;
    logic [8:0]             cnt_inc;
    logic signed [9:0]      dstep, astep, step;
    logic [FW-1:0]          frac, frac_next;
    logic                   tog_d, new_evt;
    logic signed [7:0]      delta;
    logic signed [TW-1:0]   total, shifted;
    logic signed [11:0]     sum;
    logic [OUT_W-1:0]       pos, pos_next;
    logic                   moved_r;

    always_comb begin
      rate    = fast[c] ? 8'(FAST_RATE) : 8'(SLOW_RATE);
      cnt_inc = {1'b0, cnt} + 9'd1;
      dstep   = '0;
      cnt_next = cnt;
      if (sample) begin
        if (plus[c] ^ minus[c]) begin
          if (cnt == 8'd0) dstep = plus[c] ? 10'sd1 : -10'sd1;
          cnt_next = (cnt_inc >= {1'b0, rate}) ? 8'd0 : cnt_inc[7:0];
        end else begin
          cnt_next = 8'd0;
        end
      end
    end

    // fractional remainder is the floor-mod of the accumulated delta
    always_comb begin
      new_evt   = armed & (spin_in[9*c+8] ^ tog_d);
      delta     = spin_in[9*c +: 8];
      total     = TW'(delta) + TW'(frac);
      shifted   = total >>> SPIN_SHIFT;
      astep     = '0;
      frac_next = frac;
      if (new_evt) begin
        astep     = 10'(shifted);
        frac_next = (SPIN_SHIFT > 0) ? total[FW-1:0] : '0;
      end
    end

    always_comb begin
      step = dstep + astep;
      sum  = 12'($signed({1'b0, pos})) + 12'(step);
      pos_next = sum[OUT_W-1:0];
      if (CLAMP) begin
        if (sum < 12'sd0)        pos_next = '0;
        else if (sum > MAX_POS)  pos_next = MAX_POS[OUT_W-1:0];
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt     <= 8'd0;
        frac    <= '0;
        tog_d   <= 1'b0;
        pos     <= OUT_W'(INIT);
        moved_r <= 1'b0;
      end else begin
        cnt     <= cnt_next;
        frac    <= frac_next;
        tog_d   <= spin_in[9*c+8];
        pos     <= pos_next;
        moved_r <= (pos_next != pos);
      end
    end

    assign spin_out[OUT_W*c +: OUT_W] = pos;
    assign moved[c] = moved_r;
  end

endmodule

// File: tb/tb_spinner_multi.sv
// Self-checking bench for spinner_multi: directed scenarios then randomized
// stimulus, all compared against a press-run / accumulated-delta reference model.
module tb_spinner_multi;

  localparam int CH    = 2;
  localparam int W     = 4;
  localparam int SLOW  = 8;
  localparam int FAST  = 2;
  localparam int SH    = 2;
  localparam int CLAMP = 2;
  localparam int INITV = 0;
  localparam int MAXP  = (1 << W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              strobe;
  logic [CH-1:0]     fast, minus, plus;
  logic [9*CH-1:0]   spin_in;
  logic [W*CH-1:0]   spin_out;
  logic [CH-1:0]     moved;

  int checks = 0;
  int errors = 0;
  int pulses0 = 0;

  bit m_str, m_armed;
  bit m_tog[CH];
  int m_run[CH];
  int m_acc[CH];
  int m_pos[CH];
  bit m_moved[CH];

  spinner_multi #(
    .CHANNELS(CH), .OUT_W(W), .SLOW_RATE(SLOW), .FAST_RATE(FAST),
    .SPIN_SHIFT(SH), .CLAMP_MASK(CLAMP), .INIT(INITV)
  ) dut (
    .clk(clk), .reset(reset), .strobe(strobe), .fast(fast), .minus(minus),
    .plus(plus), .spin_in(spin_in), .spin_out(spin_out), .moved(moved)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int floorDiv(input int v);
    int d, q;
    d = 1 << SH;
    q = v / d;
    if ((v % d != 0) && (v < 0)) q--;
    return q;
  endfunction

  task automatic modelReset();
    m_str = 0;
    m_armed = 0;
    for (int c = 0; c < CH; c++) begin
      m_tog[c] = 0; m_run[c] = 0; m_acc[c] = 0; m_pos[c] = INITV; m_moved[c] = 0;
    end
  endtask

  // Position = digital steps taken at press-run indices 0, rate, 2*rate, ...
  // plus floor(total analog counts / 2^SH), folded into the channel range.
  task automatic modelStep();
    bit smp;
    int d, a, rate, old, np;
    logic signed [7:0] dl;
    smp = strobe && !m_str;
    m_str = strobe;
    for (int c = 0; c < CH; c++) begin
      d = 0;
      a = 0;
      if (smp) begin
        if (plus[c] ^ minus[c]) begin
          rate = fast[c] ? FAST : SLOW;
          if (m_run[c] % rate == 0) d = plus[c] ? 1 : -1;
          m_run[c]++;
        end else begin
          m_run[c] = 0;
        end
      end
      if (m_armed && (spin_in[9*c+8] != m_tog[c])) begin
        dl = spin_in[9*c +: 8];
        old = floorDiv(m_acc[c]);
        m_acc[c] += int'(dl);
        a = floorDiv(m_acc[c]) - old;
      end
      m_tog[c] = spin_in[9*c+8];
      np = m_pos[c] + d + a;
      if ((CLAMP >> c) & 1) begin
        if (np < 0) np = 0;
        else if (np > MAXP) np = MAXP;
      end else begin
        np = ((np % (MAXP + 1)) + (MAXP + 1)) % (MAXP + 1);
      end
      m_moved[c] = (np != m_pos[c]);
      m_pos[c] = np;
    end
    m_armed = 1;
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
    pulses0 += int'(moved[0]);
    for (int c = 0; c < CH; c++) begin
      checkOutput($sformatf("pos%0d", c), int'(spin_out[W*c +: W]), m_pos[c]);
      checkOutput($sformatf("moved%0d", c), int'(moved[c]), int'(m_moved[c]));
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [CH-1:0] f, input logic [CH-1:0] mi,
                               input logic [CH-1:0] pl, input logic [9*CH-1:0] sp);
    strobe = s; fast = f; minus = mi; plus = pl; spin_in = sp;
    tick();
  endtask

  function automatic logic [9*CH-1:0] spinEvent(input logic [9*CH-1:0] sp, input int c,
                                                input logic [7:0] dl);
    logic [9*CH-1:0] r;
    r = sp;
    r[9*c+8] = ~r[9*c+8];
    r[9*c +: 8] = dl;
    return r;
  endfunction

  task automatic doReset();
    strobe = 0; fast = '0; minus = '0; plus = '0;
    reset = 1'b1;
    #1;
    checkOutput("rst_pos0", int'(spin_out[W-1:0]), INITV);
    checkOutput("rst_pos1", int'(spin_out[2*W-1:W]), INITV);
    checkOutput("rst_moved", int'(moved), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset();
    pulses0 = 0;
    applyStimulus(0, '0, '0, '0, spin_in);
  endtask

  logic [9*CH-1:0] sp;
  logic [CH-1:0]   rf, rm, rp;

  initial begin
    spin_in = '0;
    reset = 1'b0;
    strobe = 0; fast = '0; minus = '0; plus = '0;
    #2;
    doReset();

    $display("[TB] slow continuous press, 17 strobes");
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1, 2'b00, 2'b00, 2'b01, spin_in);
      applyStimulus(0, 2'b00, 2'b00, 2'b01, spin_in);
    end
    checkOutput("t1_final", int'(spin_out[W-1:0]), 3);
    checkOutput("t1_pulses", pulses0, 3);
    checkOutput("t1_ch1", int'(spin_out[2*W-1:W]), 0);

    $display("[TB] fast minus press wraps below zero");
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 2'b01, 2'b01, 2'b00, spin_in);
      if (i == 0) checkOutput("t2_first", int'(spin_out[W-1:0]), 15);
      applyStimulus(0, 2'b01, 2'b01, 2'b00, spin_in);
    end
    checkOutput("t2_final", int'(spin_out[W-1:0]), 14);
    checkOutput("t2_pulses", pulses0, 2);

    $display("[TB] clamp channel saturates at top");
    doReset();
    sp = spinEvent(spin_in, 1, 8'sd60);
    applyStimulus(0, '0, '0, '0, sp);
    checkOutput("t3_top", int'(spin_out[2*W-1:W]), 15);
    sp = spinEvent(spin_in, 1, 8'sd8);
    applyStimulus(0, '0, '0, '0, sp);
    checkOutput("t3_hold", int'(spin_out[2*W-1:W]), 15);
    checkOutput("t3_nomove", int'(moved[1]), 0);
    sp = spinEvent(spin_in, 1, -8'sd9);
    applyStimulus(0, '0, '0, '0, sp);
    checkOutput("t3_down", int'(spin_out[2*W-1:W]), 12);

    $display("[TB] fractional accumulation on wrap channel");
    doReset();
    for (int i = 0; i < 4; i++) begin
      sp = spinEvent(spin_in, 0, 8'sd1);
      applyStimulus(0, '0, '0, '0, sp);
      checkOutput("t4_frac", int'(spin_out[W-1:0]), (i == 3) ? 1 : 0);
    end
    sp = spinEvent(spin_in, 0, -8'sd1);
    applyStimulus(0, '0, '0, '0, sp);
    checkOutput("t4_neg", int'(spin_out[W-1:0]), 0);

    $display("[TB] digital and analog in the same cycle");
    doReset();
    sp = spinEvent(spin_in, 0, 8'sd8);
    applyStimulus(1, '0, '0, 2'b01, sp);
    checkOutput("t5_pos", int'(spin_out[W-1:0]), 3);
    applyStimulus(1, '0, '0, 2'b01, spin_in);
    checkOutput("t5_pulses", pulses0, 1);

    $display("[TB] asynchronous reset mid-press");
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 2'b00, 2'b00, 2'b01, spin_in);
      applyStimulus(0, 2'b00, 2'b00, 2'b01, spin_in);
    end
    sp = spinEvent(spin_in, 0, 8'sd2);
    applyStimulus(0, 2'b00, 2'b00, 2'b01, sp);
    checkOutput("t6_pre", int'(spin_out[W-1:0]), 1);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("t6_async_pos", int'(spin_out), 0);
    checkOutput("t6_async_moved", int'(moved), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset();
    applyStimulus(0, 2'b00, 2'b00, 2'b01, spin_in);
    applyStimulus(1, 2'b00, 2'b00, 2'b01, spin_in);
    checkOutput("t6_first", int'(spin_out[W-1:0]), 1);
    applyStimulus(0, 2'b00, 2'b00, 2'b01, spin_in);
    checkOutput("t6_noanalog", int'(spin_out[W-1:0]), 1);

    $display("[TB] randomized run");
    rf = '0; rm = '0; rp = '0;
    for (int i = 0; i < 3000; i++) begin
      sp = spin_in;
      for (int c = 0; c < CH; c++) begin
        if (m_run[c] == 0 && $urandom_range(0, 3) == 0) rf[c] = ~rf[c];
        if ($urandom_range(0, 7) == 0) begin
          rm[c] = 1'($urandom_range(0, 1));
          rp[c] = 1'($urandom_range(0, 1));
        end
        if ($urandom_range(0, 2) == 0)
          sp = spinEvent(sp, c, ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12) - 6));
      end
      applyStimulus(1'($urandom_range(0, 1)), rf, rm, rp, sp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
